// File: rtl/pe_sequencer_pkg.sv
// Shared constants and types for the GF(3^97) PE command front-end.
// Holds op codes, PE control words, d0 patterns and the sequencer state encoding.
package pe_sequencer_pkg;

    localparam int W     = 194;
    localparam int D0W   = 198;
    localparam int CTRLW = 11;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_CUBE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    localparam logic [CTRLW-1:0] CTRL_LOAD   = 11'b11111_000000;
    localparam logic [CTRLW-1:0] CTRL_MUL    = 11'b00000_111111;
    localparam logic [CTRLW-1:0] CTRL_CUBE   = 11'b00000_000001;
    localparam logic [CTRLW-1:0] CTRL_ADDSUB = 11'b00000_010001;

    // Top six bits of d0 select the linear-combination mode in the PE
    localparam logic [5:0] D0_CUBE = 6'b010101;
    localparam logic [5:0] D0_ADD  = 6'b000101;
    localparam logic [5:0] D0_SUB  = 6'b001001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/pe_op_decode.sv
// Combinational mapping from an op and its operands to the PE run control word
// and the d0/d1/d2 data buses.
module pe_op_decode
    import pe_sequencer_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [CTRLW-1:0] ctrl,
    output logic [D0W-1:0]   d0,
    output logic [W-1:0]     d1,
    output logic [W-1:0]     d2
);

    always_comb begin
        ctrl = CTRL_MUL;
        d0   = {4'b0000, a};
        d1   = b;
        d2   = b;
        case (op)
            OP_CUBE: begin
                ctrl = CTRL_CUBE;
                d0   = {D0_CUBE, 192'd0};
                d1   = a;
                d2   = a;
            end
            OP_ADD: begin
                ctrl = CTRL_ADDSUB;
                d0   = {D0_ADD, 192'd0};
                d1   = a;
                d2   = b;
            end
            OP_SUB: begin
                ctrl = CTRL_ADDSUB;
                d0   = {D0_SUB, 192'd0};
                d1   = a;
                d2   = b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pe_sequencer.sv
// Command front-end for one GF(3^97) PE: latches a command, walks the PE through
// CLR, LOAD and RUN_CYCLES iterations, then holds the result until it is taken.
module pe_sequencer
    import pe_sequencer_pkg::*;
#(
    parameter int RUN_CYCLES = 33,
    parameter int CW         = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             busy,
    output logic             pe_reset,
    output logic [CTRLW-1:0] pe_ctrl,
    output logic [D0W-1:0]   pe_d0,
    output logic [W-1:0]     pe_d1,
    output logic [W-1:0]     pe_d2,
    input  logic [W-1:0]     pe_out
);

    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [CTRLW-1:0] run_ctrl;
    logic             accept;

    assign cmd_ready = (state == ST_IDLE) & ~reset;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign res_data  = res_valid ? pe_out : '0;

    // Data buses come from the latched operands, so they stay put from CLR through DONE
    pe_op_decode u_decode (
        .op   (op_r),
        .a    (a_r),
        .b    (b_r),
        .ctrl (run_ctrl),
        .d0   (pe_d0),
        .d1   (pe_d1),
        .d2   (pe_d2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r <= cmd_op;
                a_r  <= cmd_a;
                b_r  <= cmd_b;
            end
            // Counter runs only inside RUN, so it is zero on every RUN entry
            if (state == ST_RUN) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pe_reset  = 1'b0;
        pe_ctrl   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                pe_reset  = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                pe_ctrl   = CTRL_LOAD;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                pe_ctrl = run_ctrl;
                if (cnt == CNT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
